rader7_feeder: RTL and testbench

//  Input reorder stage feeding the 7-point Rader DFT core. Accepts real samples
//  x[0..6] in natural order through a valid/ready handshake into a ping-pong

---
 rtl/rader7_feeder.sv | 254 +++++++++++++++++++++++++
 tb/tb_rader7_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rader7_feeder.sv
// ---------------------------------------------------------------------------
// rader7_feeder
//
// Input reorder stage in front of the 7-point Rader DFT core.
// Natural-order real samples x[0..6] arrive over a valid/ready handshake and
// are collected in a two-bank ping-pong buffer. Each complete 7-sample block
// is then replayed as one rigid 16-slot frame in Rader (generator-3) order:
//
//   slot 0      : x[0]
//   slots 1..6  : x[5], x[4], x[6], x[2], x[3], x[1]
//   slots 7..11 : x[5], x[4], x[6], x[2], x[3]
//   slots 12..15: 0
//
// This lets a bursty upstream source feed a core that needs one sample per
// cycle with no gaps inside a frame. Frames run back-to-back when the other
// bank is already full at the end of a frame.
//
// Parameters
//   W            sample width, signed two's complement
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low (0 = reset)
//   x_in         input sample, natural order
//   x_valid      x_in valid this cycle
//   x_ready      a bank slot is free; transfer on x_valid & x_ready
//   x_out        registered frame sample to the DFT core
//   frame_start  registered; high while x_out carries slot 0
//   busy         registered; high for all 16 slots of a frame
//   underrun     (only with RADER7_UNDERRUN_EN) sticky flag, set when a
//                frame ends and no next block is waiting
//
// Configuration macro
//   RADER7_UNDERRUN_EN  adds the underrun output and its logic
// ---------------------------------------------------------------------------
module rader7_feeder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [W-1:0] x_out,
  output logic         frame_start,
  output logic         busy
`ifdef RADER7_UNDERRUN_EN
 ,output logic         underrun
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;

  // Ping-pong sample storage: two banks of seven samples.
  logic [W-1:0] mem [2][7];
  logic [1:0]   full;

  // Write side pointers
  logic         wr_bank;
  logic [2:0]   wr_idx;
  logic         accept;
  logic         wr_last;

  // Read side state
  logic         rd_bank;
  logic         rd_bank_next;
  logic [3:0]   slot;
  logic [3:0]   slot_next;
  logic         frame_end;

  // Which sample the next registered output carries
  logic         emit_en;
  logic         emit_bank;
  logic [3:0]   emit_slot;
  logic [2:0]   emit_idx;
  logic         emit_zero;

  logic [W-1:0] x_out_next;
  logic         frame_start_next;
  logic         busy_next;

  // x_ready depends only on registered flags, so there is no combinational
  // path from x_valid back to x_ready.
  assign x_ready = ~full[wr_bank];
  assign accept  = x_valid & x_ready;
  assign wr_last = (wr_idx == 3'd6);

  // Sample storage carries no reset: the pointers and full flags decide
  // what is valid, so stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][wr_idx] <= x_in;
    end
  end

  // Write pointer: the seventh transfer closes the block and moves on to
  // the other bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank <= 1'b0;
      wr_idx  <= 3'd0;
    end else if (accept) begin
      if (wr_last) begin
        wr_idx  <= 3'd0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx  <= wr_idx + 3'd1;
      end
    end
  end

  // Bank full flags. A clear at the end of a frame and a set from the
  // seventh transfer can land on the same edge; they always target
  // different banks because the bank being read is full and therefore
  // cannot be the bank being written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 2'b00;
    end else begin
      if (frame_end) begin
        full[rd_bank] <= 1'b0;
      end
      if (accept && wr_last) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

  // Read FSM state register. 'slot' is the slot currently shown on x_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      slot    <= 4'd0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_next;
      slot    <= slot_next;
      rd_bank <= rd_bank_next;
    end
  end

  // Read FSM next state. The outputs are registered, so this block decides
  // which slot of which bank appears on x_out after the coming edge. From
  // IDLE, slot 0 is launched on the first edge that sees the bank full,
  // one cycle after the seventh transfer. At slot 15 the frame hands over
  // to the other bank without a gap when that bank is ready.
  always_comb begin
    state_next       = state;
    slot_next        = slot;
    rd_bank_next     = rd_bank;
    emit_en          = 1'b0;
    emit_bank        = rd_bank;
    emit_slot        = 4'd0;
    frame_start_next = 1'b0;
    busy_next        = 1'b0;
    frame_end        = 1'b0;

    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_next       = RUN;
          slot_next        = 4'd0;
          emit_en          = 1'b1;
          emit_slot        = 4'd0;
          frame_start_next = 1'b1;
          busy_next        = 1'b1;
        end
      end

      RUN: begin
        if (slot != 4'd15) begin
          slot_next = slot + 4'd1;
          emit_en   = 1'b1;
          emit_slot = slot + 4'd1;
          busy_next = 1'b1;
        end else begin
          frame_end    = 1'b1;
          rd_bank_next = ~rd_bank;
          slot_next    = 4'd0;
          if (full[~rd_bank]) begin
            emit_en          = 1'b1;
            emit_bank        = ~rd_bank;
            emit_slot        = 4'd0;
            frame_start_next = 1'b1;
            busy_next        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Rader generator-3 slot map. Slots 7..11 repeat the head of the
  // permuted sequence so the core's circular convolution sees it wrap
  // without extra storage; slots 12..15 are zero padding.
  always_comb begin
    emit_idx  = 3'd0;
    emit_zero = 1'b0;
    case (emit_slot)
      4'd0:         emit_idx = 3'd0;
      4'd1, 4'd7:   emit_idx = 3'd5;
      4'd2, 4'd8:   emit_idx = 3'd4;
      4'd3, 4'd9:   emit_idx = 3'd6;
      4'd4, 4'd10:  emit_idx = 3'd2;
      4'd5, 4'd11:  emit_idx = 3'd3;
      4'd6:         emit_idx = 3'd1;
      default:      emit_zero = 1'b1;
    endcase
  end

  assign x_out_next = (emit_en && !emit_zero) ? mem[emit_bank][emit_idx] : '0;

  // Output registers feeding the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out       <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      x_out       <= x_out_next;
      frame_start <= frame_start_next;
      busy        <= busy_next;
    end
  end

`ifdef RADER7_UNDERRUN_EN
  logic underrun_set;

  // A frame ending with nothing queued behind it leaves a hole in the
  // core's input schedule.
  assign underrun_set = frame_end & ~full[~rd_bank];

  // Sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rader7_feeder.sv
// ---------------------------------------------------------------------------
// tb_rader7_feeder
//
// Directed bench for rader7_feeder. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. A monitor collects
// every busy x_out value and the cycle of each frame_start so frame streams
// can be compared against hand-written expectations afterwards.
// Build with RADER7_UNDERRUN_EN defined to also exercise the underrun flag.
// ---------------------------------------------------------------------------
module tb_rader7_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] x_in;
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] x_out;
  logic         frame_start;
  logic         busy;
`ifdef RADER7_UNDERRUN_EN
  logic         underrun;
`endif

  int checks_total  = 0;
  int checks_passed = 0;

  int out_q[$];
  int fs_cyc_q[$];
  int cycle_num = 0;

  // Rader read order of the 16 slots; -1 marks a zero slot.
  int slot_order[16] = '{0, 5, 4, 6, 2, 3, 1, 5, 4, 6, 2, 3, -1, -1, -1, -1};

  rader7_feeder #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .x_in        (x_in),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .x_out       (x_out),
    .frame_start (frame_start),
    .busy        (busy)
`ifdef RADER7_UNDERRUN_EN
   ,.underrun    (underrun)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: record every emitted slot and where each frame begins.
  always @(negedge clk) begin
    cycle_num <= cycle_num + 1;
    if (busy) begin
      out_q.push_back(int'($signed(x_out)));
      if (frame_start) begin
        fs_cyc_q.push_back(cycle_num);
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks_total++;
    if (observed == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Hold reset for two edges, release mid-cycle, return aligned at posedge+1.
  task automatic doReset();
    reset   = 1'b0;
    x_valid = 1'b0;
    x_in    = '0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and wait until it is taken; reports cycles stalled.
  task automatic applyStimulus(input int value, output int stalls);
    bit ok;
    x_in    = W'(value);
    x_valid = 1'b1;
    stalls  = 0;
    forever begin
      @(negedge clk);
      ok = x_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      stalls++;
      if (stalls > 200) begin
        checkOutput("ready_timeout", stalls, 0);
        break;
      end
    end
  endtask

  task automatic waitOutputs(input int target, input int budget);
    int n = 0;
    while (out_q.size() < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (out_q.size() < target) begin
      checkOutput("output_timeout", out_q.size(), target);
    end
  endtask

  initial begin
    int st;
    int stv[28];
    int sum;
    int base_o;
    int base_f;
    int exp_t2[16] = '{1, 6, 5, 7, 3, 4, 2, 6, 5, 7, 3, 4, 0, 0, 0, 0};
    int vals_t5[7] = '{-128, 127, 0, -1, 1, 64, -64};
    int exp_t5[16] = '{-128, 64, 1, -64, 0, -1, 127, 64, 1, -64, 0, -1, 0, 0, 0, 0};
    int e;

    $display("[TB] starting rader7_feeder bench");

    // Reset state while reset is held low
    reset   = 1'b0;
    x_valid = 1'b0;
    x_in    = '0;
    #2;
    checkOutput("rst_x_out", int'($signed(x_out)), 0);
    checkOutput("rst_frame_start", int'(frame_start), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_x_ready", int'(x_ready), 1);

    // T2: single block 1..7 and exact latency/order
    doReset();
    for (int k = 0; k < 7; k++) applyStimulus(k + 1, st);
    x_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_pre_frame_start", int'(frame_start), 0);
    checkOutput("t2_pre_busy", int'(busy), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_slot%0d", i), int'($signed(x_out)), exp_t2[i]);
      checkOutput($sformatf("t2_fs%0d", i), int'(frame_start), (i == 0) ? 1 : 0);
      checkOutput($sformatf("t2_busy%0d", i), int'(busy), 1);
    end
    @(negedge clk);
    checkOutput("t2_post_busy", int'(busy), 0);
    checkOutput("t2_post_x_out", int'($signed(x_out)), 0);
    checkOutput("t2_post_x_ready", int'(x_ready), 1);
`ifdef RADER7_UNDERRUN_EN
    checkOutput("t6_underrun_set", int'(underrun), 1);
    repeat (5) @(negedge clk);
    checkOutput("t6_underrun_sticky", int'(underrun), 1);
`endif

    // T3: 14 samples back-to-back give two contiguous frames
    doReset();
`ifdef RADER7_UNDERRUN_EN
    checkOutput("t6_underrun_cleared", int'(underrun), 0);
`endif
    base_o = out_q.size();
    base_f = fs_cyc_q.size();
    sum = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(11 + k, st);
      sum += st;
    end
    x_valid = 1'b0;
    checkOutput("t3_no_stall", sum, 0);
    waitOutputs(base_o + 32, 80);
    checkOutput("t3_frames", fs_cyc_q.size() - base_f, 2);
    if (fs_cyc_q.size() - base_f >= 2)
      checkOutput("t3_fs_spacing", fs_cyc_q[base_f + 1] - fs_cyc_q[base_f], 16);
    for (int i = 0; i < 32 && base_o + i < out_q.size(); i++) begin
      e = (slot_order[i % 16] < 0) ? 0 : 11 + 7 * (i / 16) + slot_order[i % 16];
      checkOutput($sformatf("t3_out%0d", i), out_q[base_o + i], e);
    end

    // T4: continuous x_valid, backpressure and no loss/duplication
    doReset();
    base_o = out_q.size();
    base_f = fs_cyc_q.size();
    for (int k = 0; k < 28; k++) applyStimulus(31 + k, stv[k]);
    x_valid = 1'b0;
`ifdef RADER7_UNDERRUN_EN
    checkOutput("t6_no_underrun_stream", int'(underrun), 0);
`endif
    sum = 0;
    for (int k = 0; k < 14; k++) sum += stv[k];
    checkOutput("t4_first14_no_stall", sum, 0);
    checkOutput("t4_stall_sample15", stv[14], 10);
    checkOutput("t4_stall_sample22", stv[21], 9);
    sum = 0;
    for (int k = 15; k < 28; k++) if (k != 21) sum += stv[k];
    checkOutput("t4_other_stalls", sum, 0);
    waitOutputs(base_o + 64, 120);
    checkOutput("t4_frames", fs_cyc_q.size() - base_f, 4);
    for (int f = 1; f < 4 && base_f + f < fs_cyc_q.size(); f++)
      checkOutput($sformatf("t4_fs_spacing%0d", f),
                  fs_cyc_q[base_f + f] - fs_cyc_q[base_f + f - 1], 16);
    for (int i = 0; i < 64 && base_o + i < out_q.size(); i++) begin
      e = (slot_order[i % 16] < 0) ? 0 : 31 + 7 * (i / 16) + slot_order[i % 16];
      checkOutput($sformatf("t4_out%0d", i), out_q[base_o + i], e);
    end
`ifdef RADER7_UNDERRUN_EN
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_underrun_after_stream", int'(underrun), 1);
`endif

    // T5: signed extremes pass unchanged
    doReset();
    base_o = out_q.size();
    for (int k = 0; k < 7; k++) applyStimulus(vals_t5[k], st);
    x_valid = 1'b0;
    waitOutputs(base_o + 16, 40);
    for (int i = 0; i < 16 && base_o + i < out_q.size(); i++)
      checkOutput($sformatf("t5_out%0d", i), out_q[base_o + i], exp_t5[i]);

    // T1: asynchronous reset mid-frame
    doReset();
    for (int k = 0; k < 7; k++) applyStimulus(k + 1, st);
    x_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("t1_x_out", int'($signed(x_out)), 0);
    checkOutput("t1_frame_start", int'(frame_start), 0);
    checkOutput("t1_busy", int'(busy), 0);
    checkOutput("t1_x_ready", int'(x_ready), 1);

    // Reset mid-block: partial samples discarded, new block starts at x[0]
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(90 + k, st);
    x_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("t1b_busy", int'(busy), 0);
    doReset();
    base_o = out_q.size();
    for (int k = 0; k < 7; k++) applyStimulus(100 + k, st);
    x_valid = 1'b0;
    waitOutputs(base_o + 16, 40);
    if (base_o + 7 <= out_q.size()) begin
      checkOutput("t1b_slot0", out_q[base_o], 100);
      checkOutput("t1b_slot1", out_q[base_o + 1], 105);
      checkOutput("t1b_slot6", out_q[base_o + 6], 101);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
